inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Instruction-fetch controller between the core's instruction-ROM port (rom_ce_o / rom_addr_o / rom_data_i) and an external wait-state instruction memory with req/ack handshake.
- Holds a one-entry fetched-word buffer. Repeated fetches of the buffered address are served with zero wait.
- On a miss, raises stallreq_o to the core, runs the memory transaction and refills the buffer.
- A timeout counter converts a hung memory into a NOP plus an error pulse, so the pipeline never deadlocks.

Parameters:
- ADDR_W, 32, instruction address width (matches `InstAddrBus).
- DATA_W, 32, instruction word width (matches `InstBus).
- TIMEOUT, 16, maximum cycles in REQ without ack before abort; legal range 2..256.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable = 1'b1).
- rom_ce_i  in  1  fetch enable from pc_reg (`ChipEnable = 1).
- rom_addr_i  in  ADDR_W  fetch address (PC) from core.
- rom_data_o  out  DATA_W  instruction word to if_id.
- stallreq_o  out  1  fetch stall request to core stall logic.
- mem_req_o  out  1  memory request, level-held until ack or timeout.
- mem_addr_o  out  ADDR_W  memory address, stable while mem_req_o=1.
- mem_ack_i  in  1  one-cycle ack; mem_rdata_i valid in the same cycle.
- mem_rdata_i  in  DATA_W  memory read data.
- err_o  out  1  one-cycle pulse on fetch timeout.

Behaviour:
- State: buf_valid, buf_tag[ADDR_W], buf_data[DATA_W], FSM {IDLE, REQ}, tmo_cnt (clog2(TIMEOUT) bits), req_addr.
- Reset (rst=1 at clk edge), regardless of the current state:
  - FSM=IDLE, buf_valid=0, tmo_cnt=0.
  - mem_req_o=0, mem_addr_o=0, err_o=0.
  - rom_data_o=`ZeroWord, stallreq_o=0 while rst=1.
  - An in-flight memory transaction is dropped; the memory must tolerate req deassertion.
- Hit, defined as rom_ce_i & buf_valid & (buf_tag==rom_addr_i):
  - rom_data_o=buf_data (combinational), stallreq_o=0.
- rom_ce_i=0: rom_data_o=`ZeroWord, stallreq_o=0, no new request issued.
- Miss, defined as rom_ce_i & !hit:
  - stallreq_o=1 combinationally in the same cycle. rom_data_o=`ZeroWord.
  - If FSM=IDLE: at the next edge req_addr<=rom_addr_i, FSM<=REQ, tmo_cnt<=0.
- REQ state:
  - mem_req_o=1, mem_addr_o=req_addr.
  - tmo_cnt increments each cycle without ack.
- Ack in REQ:
  - At the edge: buf_tag<=req_addr, buf_data<=mem_rdata_i, buf_valid<=1, FSM<=IDLE.
  - Next cycle is a hit if the core held its address.
- Latency: miss at cycle 0, ack at cycle k≥1 → data on rom_data_o with stallreq_o=0 at cycle k+1. Zero-wait memory (ack in the first REQ cycle) gives 2 cycles per miss.
- Timeout: in REQ with tmo_cnt==TIMEOUT-1 and no ack, at the edge:
  - buf_tag<=req_addr, buf_data<=`ZeroWord (NOP), buf_valid<=1, FSM<=IDLE.
  - err_o=1 for exactly the following cycle.
- Ack coincident with the timeout cycle: ack wins; real data is loaded and err_o stays 0.
- Address change while in REQ (core not honouring the stall, or rom_ce_i dropped):
  - The transaction completes to req_addr and the buffer is filled with it.
  - The new address then misses and triggers a fresh request.
- mem_addr_o holds its last value while in IDLE; mem_req_o=0 in IDLE always.
- mem_ack_i while in IDLE is ignored.

Decomposition:
- Widths, `ZeroWord, `RstEnable, `ChipEnable, and new macros `FetchIdle / `FetchReq and `FetchTimeout come from the shared define package.
- No sub-module.
- Core-side stall plumbing into pc_reg and if_id is a separate change.

Test Plan:
- Reset mid-REQ: after addr 0x0000_0004 miss, assert rst in 2nd REQ cycle → next cycle mem_req_o=0, FSM=IDLE, buf_valid=0, stallreq_o=0.
- Cold miss, zero-wait memory: addr 0x0000_0000 miss, ack in 1st REQ cycle with 0x3401_1100 → stallreq_o=1 for cycles 0–1, rom_data_o=0x3401_1100 with stallreq_o=0 at cycle 2.
- Sequential fetch, 3-wait-state memory: PCs 0x0, 0x4, 0x8 each miss → each word delivered 5 cycles after its miss; mem_addr_o stable throughout each REQ.
- Hit: hold addr 0x0000_0008 after fill for 4 cycles → no mem_req_o, stallreq_o=0, data constant.
- Timeout: TIMEOUT=16, never ack addr 0x0000_0010 → mem_req_o high exactly 16 cycles, err_o one-cycle pulse, rom_data_o=0x0000_0000 and stallreq_o=0 on the next cycle. Ack on the 16th cycle with 0xDEAD_BEEF → data loaded, err_o=0.
- rom_ce_i=0 with any address → rom_data_o=0, stallreq_o=0, no request.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared fetch-path definitions: bus widths, control levels and fetch FSM states.
package inst_fetch_ctrl_pkg;

    localparam int INST_ADDR_W   = 32;
    localparam int INST_DATA_W   = 32;
    localparam int FETCH_TIMEOUT = 16;

    localparam logic RST_ENABLE  = 1'b1;
    localparam logic CHIP_ENABLE = 1'b1;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_REQ  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: one-entry fetched-word buffer in front of a
// req/ack wait-state instruction memory, with a timeout that turns a hung
// memory into a NOP plus an error pulse so the pipeline never deadlocks.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W  = INST_ADDR_W,
    parameter int DATA_W  = INST_DATA_W,
    parameter int TIMEOUT = FETCH_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [ADDR_W-1:0] rom_addr_i,
    output logic [DATA_W-1:0] rom_data_o,
    output logic              stallreq_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e      state;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_tag;
    logic [DATA_W-1:0] buf_data;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [ADDR_W-1:0] req_addr;
    logic              hit;
    logic              miss;

    assign hit        = (rom_ce_i == CHIP_ENABLE) && buf_valid && (buf_tag == rom_addr_i);
    assign miss       = (rom_ce_i == CHIP_ENABLE) && !hit;
    assign mem_addr_o = req_addr;

    // Core-facing side: serve buffered word on a hit, stall the core on a miss.
    always_comb begin
        rom_data_o = '0;
        stallreq_o = 1'b0;
        if (rst != RST_ENABLE) begin
            if (hit) begin
                rom_data_o = buf_data;
            end
            stallreq_o = miss;
        end
    end

    // Fetch FSM: launch a request on a miss, refill the buffer on ack or timeout.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state     <= FETCH_IDLE;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            tmo_cnt   <= '0;
            req_addr  <= '0;
            mem_req_o <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                FETCH_IDLE: begin
                    if (miss) begin
                        req_addr  <= rom_addr_i;
                        tmo_cnt   <= '0;
                        mem_req_o <= 1'b1;
                        state     <= FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (mem_ack_i) begin
                        buf_tag   <= req_addr;
                        buf_data  <= mem_rdata_i;
                        buf_valid <= 1'b1;
                        mem_req_o <= 1'b0;
                        state     <= FETCH_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        buf_tag   <= req_addr;
                        buf_data  <= '0;
                        buf_valid <= 1'b1;
                        mem_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        state     <= FETCH_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    mem_req_o <= 1'b0;
                    state     <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model.
module tb_inst_fetch_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        stallreq;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    int tests    = 0;
    int failures = 0;

    // Reference model: buffered word, outstanding transaction, pending error pulse.
    logic        m_valid;
    logic [31:0] m_tag;
    logic [31:0] m_data;
    logic        m_busy;
    logic [31:0] m_addr;
    int          m_reqcycle;
    logic        m_err;

    inst_fetch_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce),
        .rom_addr_i (rom_addr),
        .rom_data_o (rom_data),
        .stallreq_o (stallreq),
        .mem_req_o  (mem_req),
        .mem_addr_o (mem_addr),
        .mem_ack_i  (mem_ack),
        .mem_rdata_i(mem_rdata),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs and compare every output with the model.
    task automatic applyStimulus(input logic r, input logic ce, input logic [31:0] a,
                                 input logic ack, input logic [31:0] d);
        logic        m_hit;
        logic [31:0] exp_data;
        logic        exp_stall;
        rst       = r;
        rom_ce    = ce;
        rom_addr  = a;
        mem_ack   = ack;
        mem_rdata = d;
        #1;
        m_hit     = ce && m_valid && (m_tag == a);
        exp_data  = (!r && m_hit) ? m_data : 32'h0;
        exp_stall = !r && ce && !m_hit;
        checkOutput("rom_data", rom_data, exp_data);
        checkOutput("stallreq", {31'b0, stallreq}, {31'b0, exp_stall});
        checkOutput("mem_req", {31'b0, mem_req}, {31'b0, m_busy});
        checkOutput("mem_addr", mem_addr, m_addr);
        checkOutput("err", {31'b0, err}, {31'b0, m_err});
    endtask

    // Advance the model by the rules of one clock edge, then move past the edge.
    task automatic nextCycle();
        logic m_hit;
        m_hit = rom_ce && m_valid && (m_tag == rom_addr);
        if (rst) begin
            m_valid = 1'b0; m_tag = '0; m_data = '0;
            m_busy = 1'b0; m_addr = '0; m_reqcycle = 0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_busy) begin
                if (mem_ack) begin
                    m_valid = 1'b1; m_tag = m_addr; m_data = mem_rdata; m_busy = 1'b0;
                end else if (m_reqcycle == TMO) begin
                    m_valid = 1'b1; m_tag = m_addr; m_data = 32'h0; m_busy = 1'b0; m_err = 1'b1;
                end else begin
                    m_reqcycle++;
                end
            end else if (rom_ce && !m_hit) begin
                m_busy = 1'b1; m_addr = rom_addr; m_reqcycle = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic ce, input logic [31:0] a,
                        input logic ack, input logic [31:0] d);
        applyStimulus(r, ce, a, ack, d);
        nextCycle();
    endtask

    initial begin
        int          req_cycles;
        int          err_cycles;
        logic [31:0] words [3];
        logic [31:0] ra;
        logic        rce;
        logic        rack;

        m_valid = 1'b0; m_tag = '0; m_data = '0;
        m_busy = 1'b0; m_addr = '0; m_reqcycle = 0; m_err = 1'b0;
        rst = 1'b1; rom_ce = 1'b0; rom_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        words[0] = 32'h1111_0001;
        words[1] = 32'h2222_0002;
        words[2] = 32'h3333_0003;

        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset state
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("reset_mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("reset_err", {31'b0, err}, 32'h0);
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        nextCycle();

        // Cold miss with a zero-wait memory
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
        checkOutput("cold_stall_c0", {31'b0, stallreq}, 32'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 32'h3401_1100);
        checkOutput("cold_stall_c1", {31'b0, stallreq}, 32'h1);
        checkOutput("cold_req_c1", {31'b0, mem_req}, 32'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
        checkOutput("cold_data_c2", rom_data, 32'h3401_1100);
        checkOutput("cold_stall_c2", {31'b0, stallreq}, 32'h0);
        nextCycle();

        // Reset in the second REQ cycle of a miss to 0x4
        step(1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h4, 1'b0, 32'h0);
        checkOutput("rst_mid_stall", {31'b0, stallreq}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h4, 1'b0, 32'h0);
        checkOutput("rst_mid_req", {31'b0, mem_req}, 32'h0);
        checkOutput("rst_mid_stall_after", {31'b0, stallreq}, 32'h0);
        nextCycle();

        // Sequential fetch, 3 wait states; address 0 must miss again after reset
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c <= 5; c++) begin
                applyStimulus(1'b0, 1'b1, 32'(p * 4), c == 4, (c == 4) ? words[p] : 32'hBAD0_0000);
                if (c >= 1 && c <= 4) begin
                    checkOutput("seq_mem_addr", mem_addr, 32'(p * 4));
                end
                if (c == 5) begin
                    checkOutput("seq_data", rom_data, words[p]);
                    checkOutput("seq_stall", {31'b0, stallreq}, 32'h0);
                end else begin
                    checkOutput("seq_stall_wait", {31'b0, stallreq}, 32'h1);
                end
                if (c < 5) nextCycle();
            end
            nextCycle();
        end

        // Hold address 0x8: hits with no memory traffic
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b1, 32'h8, 1'b0, 32'h0);
            checkOutput("hit_data", rom_data, words[2]);
            checkOutput("hit_req", {31'b0, mem_req}, 32'h0);
            nextCycle();
        end

        // Hung memory at 0x10
        req_cycles = 0;
        err_cycles = 0;
        for (int c = 0; c < 19; c++) begin
            applyStimulus(1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
            if (mem_req) req_cycles++;
            if (err) err_cycles++;
            if (c == 17) begin
                checkOutput("tmo_err", {31'b0, err}, 32'h1);
                checkOutput("tmo_nop", rom_data, 32'h0);
                checkOutput("tmo_stall", {31'b0, stallreq}, 32'h0);
            end
            nextCycle();
        end
        checkOutput("tmo_req_cycles", 32'(req_cycles), 32'd16);
        checkOutput("tmo_err_cycles", 32'(err_cycles), 32'd1);

        // Ack on the last allowed REQ cycle beats the timeout
        for (int c = 0; c < 18; c++) begin
            applyStimulus(1'b0, 1'b1, 32'h14, c == 16, (c == 16) ? 32'hDEAD_BEEF : 32'h0);
            if (c == 17) begin
                checkOutput("late_ack_data", rom_data, 32'hDEAD_BEEF);
                checkOutput("late_ack_err", {31'b0, err}, 32'h0);
            end
            nextCycle();
        end

        // Fetch disabled: no data, no stall, no request
        for (int c = 0; c < 4; c++) begin
            ra = $urandom;
            applyStimulus(1'b0, 1'b0, ra, 1'b0, 32'h0);
            checkOutput("ce_off_data", rom_data, 32'h0);
            checkOutput("ce_off_stall", {31'b0, stallreq}, 32'h0);
            nextCycle();
            checkOutput("ce_off_req", {31'b0, mem_req}, 32'h0);
        end

        // Randomized traffic: address changes mid-request, stray acks, timeouts, resets
        ra = 32'h0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) < 3) ra = 32'($urandom_range(0, 7)) << 2;
            rce  = ($urandom_range(0, 9) != 0);
            rack = m_busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 99) == 0, rce, ra, rack, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
